// File: rtl/alu_result_uart_tx.sv
// Captures strobed ALU result bytes into a small FIFO and drains them as
// 8N1 serial frames (start, 8 data bits LSB first, stop) on a single tx pin.
module alu_result_uart_tx #(
  parameter int DEPTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   data_in,
  input  logic                         wr_en,
  output logic                         tx,
  output logic                         busy,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [2:0]        bit_idx, bit_nxt;
  logic [7:0]        shift, shift_nxt;
  logic              baud_end;

  // full is decoded from the registered count, so a write while full is
  // dropped even when the serializer pops in the same cycle.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;

  // FIFO control stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Serializer state stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_nxt;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end

  assign baud_end = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          baud_nxt  = '0;
        end
      end
      START: begin
        if (baud_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt  = '0;
          shift_nxt = shift >> 1;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_nxt   = bit_idx + 3'd1;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
        end else begin
          baud_nxt = baud + BAUD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is decoded purely from registered state.
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: frame-timeline reference model checked every
// cycle, a serial line decoder, and directed scenarios with literal expectations.
module tb_alu_result_uart_tx;
  localparam int DEPTH = 8;
  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       wr_en = 1'b0;
  logic       tx, busy, full, empty, overflow;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  alu_result_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .wr_en(wr_en),
    .tx(tx), .busy(busy), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a frame timeline position.
  logic [7:0] mq[$];
  bit         m_in  = 1'b0;
  int         m_pos = 0;
  logic [7:0] m_byte = 8'h00;
  bit         m_ovf = 1'b0;

  function automatic logic frame_bit(input int pos, input logic [7:0] b);
    int k;
    k = pos / C;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_in  = 1'b0;
      m_pos = 0;
      m_ovf = 1'b0;
    end else begin
      bit full_pre;
      full_pre = (mq.size() == DEPTH);
      if (m_in) begin
        if (m_pos == FRAME - 1) m_in = 1'b0;
        else m_pos++;
      end else if (mq.size() != 0) begin
        m_byte = mq.pop_front();
        m_in   = 1'b1;
        m_pos  = 0;
      end
      if (wr_en) begin
        if (!full_pre) mq.push_back(data_in);
        else m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_tx;
      exp_tx = m_in ? frame_bit(m_pos, m_byte) : 1'b1;
      check("model_tx", {31'd0, tx}, {31'd0, exp_tx});
      check("model_status", {24'd0, busy, count, empty, full, overflow},
            {24'd0, m_in, 4'(mq.size()), mq.size() == 0, mq.size() == DEPTH, m_ovf});
    end
  end

  // Serial line decoder: samples each bit in the first cycle of its slot.
  logic [7:0] rx_q[$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_b = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % C == 0 && rx_cnt <= 8 * C) rx_b[rx_cnt / C - 1] = tx;
      if (rx_cnt == 9 * C) begin
        check("rx_stop_bit", {31'd0, tx}, 32'd1);
        rx_q.push_back(rx_b);
        rx_act = 1'b0;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    data_in = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (!(empty && !busy) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
      check(name, {24'd0, rx_q[i]}, {24'd0, exp[i]});
  endtask

  initial begin
    logic [7:0] exp[$];
    int n, peak;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_count", {28'd0, count}, 32'd0);
    check("rst_flags", {29'd0, empty, full, overflow}, 32'b100);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_empty", {31'd0, empty}, 32'd1);

    // Single byte A5: busy for exactly one frame
    push_byte(8'hA5);
    n = 0;
    while (!busy && n < 5) begin @(negedge clk); n++; end
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("a5_busy_cycles", n, 40);
    check("a5_count", {28'd0, count}, 32'd0);
    exp = '{8'hA5};
    check_rx("a5_rx", exp);
    rx_q.delete();

    // Three consecutive pushes
    @(negedge clk);
    wr_en = 1'b1; data_in = 8'h01;
    @(negedge clk); data_in = 8'h02;
    peak = count;
    @(negedge clk); data_in = 8'h03;
    if (count > peak) peak = count;
    @(negedge clk); wr_en = 1'b0;
    n = 0;
    while (!(empty && !busy) && n < 400) begin
      if (count > peak) peak = count;
      @(negedge clk);
      n++;
    end
    check("three_peak_count", peak, 2);
    exp = '{8'h01, 8'h02, 8'h03};
    check_rx("three_rx", exp);
    rx_q.delete();

    // Fill to full, then overflow
    @(negedge clk);
    wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      data_in = 8'h10 + 8'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {28'd0, count}, 32'd8);
    check("fill_ovf", {31'd0, overflow}, 32'd0);
    push_byte(8'hFF);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    wait_drain(600);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    check_rx("fill_rx", exp);
    rx_q.delete();

    // Reset mid-frame
    push_byte(8'h3C);
    repeat (15) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_count", {28'd0, count}, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("abort_no_frame", rx_q.size(), 0);

    // Wrap-around: 20 bytes in bursts of 5
    exp.delete();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      wr_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
        data_in = 8'(b * 5 + i);
        exp.push_back(8'(b * 5 + i));
        @(negedge clk);
      end
      wr_en = 1'b0;
      wait_drain(400);
    end
    check_rx("wrap_rx", exp);
    check("wrap_ovf", {31'd0, overflow}, 32'd0);
    check("wrap_empty", {31'd0, empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
